// File: rtl/path_delay_probe_ctrl.sv
// path_delay_probe_ctrl
//   Runs N timing-probe trials on one delay chain. Each trial toggles the
//   chain input, captures the chain output S+1 cycles later, compares it
//   with the expected level and tallies the outcome. Fails are split by the
//   direction of the launch edge.
//
// Ports
//   clk, rst_n       : clock, synchronous active-low reset
//   start            : run request, accepted only while idle
//   settle_cycles    : S, capture delay after launch in cycles
//   num_trials       : N, trials per run (0 = empty run)
//   expect_invert    : chain has odd inverting depth
//   path_input       : registered drive into the chain
//   path_result      : chain output, asynchronous to clk
//   busy, done       : run in progress / one-cycle end-of-run pulse
//   pass_count       : trials whose capture matched the expectation
//   fail_rise_count  : mismatches on rising launches
//   fail_fall_count  : mismatches on falling launches
module path_delay_probe_ctrl #(
  parameter int SETTLE_W = 8,
  parameter int TRIAL_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [SETTLE_W-1:0] settle_cycles,
  input  logic [TRIAL_W-1:0]  num_trials,
  input  logic                expect_invert,
  output logic                path_input,
  input  logic                path_result,
  output logic                busy,
  output logic                done,
  output logic [TRIAL_W-1:0]  pass_count,
  output logic [TRIAL_W-1:0]  fail_rise_count,
  output logic [TRIAL_W-1:0]  fail_fall_count
);

  typedef enum logic [2:0] {IDLE, PRIME, LAUNCH, WAIT, CAPTURE, TALLY, HOLD} state_e;

  localparam int CNT_W = SETTLE_W + 2;
  localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);
  localparam logic [TRIAL_W-1:0] TRL_ONE = TRIAL_W'(1);

  state_e                state_q;
  logic [SETTLE_W-1:0]   s_q;
  logic [TRIAL_W-1:0]    n_q;
  logic                  inv_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [TRIAL_W-1:0]    idx_q;
  logic                  rise_q;
  logic                  last_q;
  logic                  sample_q;
  logic                  path_q;
  logic                  busy_q;
  logic                  done_q;
  logic [TRIAL_W-1:0]    pass_q;
  logic [TRIAL_W-1:0]    frise_q;
  logic [TRIAL_W-1:0]    ffall_q;
  logic [CNT_W-1:0]      s_ext;

  assign s_ext = {2'b00, s_q};

  // Cycle timing, relative to the accepting edge A and launch edge Ek:
  //   PRIME   : A+1 .. A+S+1       (first launch at A+S+2)
  //   WAIT    : Ek+1 .. Ek+S       (skipped when S=0)
  //   CAPTURE : Ek+S+1
  //   TALLY   : Ek+S+2
  //   HOLD    : Ek+S+3 .. Ek+2S+4  (next launch at Ek+2S+5)
  // The final HOLD cycle after the last tally is replaced by the done pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      s_q      <= '0;
      n_q      <= '0;
      inv_q    <= 1'b0;
      cnt_q    <= '0;
      idx_q    <= '0;
      rise_q   <= 1'b0;
      last_q   <= 1'b0;
      sample_q <= 1'b0;
      path_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= '0;
      frise_q  <= '0;
      ffall_q  <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            s_q     <= settle_cycles;
            n_q     <= num_trials;
            inv_q   <= expect_invert;
            pass_q  <= '0;
            frise_q <= '0;
            ffall_q <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= PRIME;
          end
        end
        PRIME: begin
          if (n_q == '0) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (cnt_q == s_ext) begin
            state_q <= LAUNCH;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        LAUNCH: begin
          path_q  <= ~path_q;
          rise_q  <= ~path_q;
          cnt_q   <= CNT_ONE;
          state_q <= (s_q == '0) ? CAPTURE : WAIT;
        end
        WAIT: begin
          if (cnt_q == s_ext) state_q <= CAPTURE;
          else                cnt_q   <= cnt_q + CNT_ONE;
        end
        CAPTURE: begin
          // Single capture flop by design: a synchronizer would shift the window.
          sample_q <= path_result;
          state_q  <= TALLY;
        end
        TALLY: begin
          if (sample_q == (path_q ^ inv_q)) pass_q  <= pass_q + TRL_ONE;
          else if (rise_q)                  frise_q <= frise_q + TRL_ONE;
          else                              ffall_q <= ffall_q + TRL_ONE;
          last_q  <= ((idx_q + TRL_ONE) == n_q);
          idx_q   <= idx_q + TRL_ONE;
          cnt_q   <= '0;
          state_q <= HOLD;
        end
        HOLD: begin
          if (last_q) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (cnt_q == (s_ext + CNT_ONE)) begin
            state_q <= LAUNCH;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign path_input      = path_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass_count      = pass_q;
  assign fail_rise_count = frise_q;
  assign fail_fall_count = ffall_q;

endmodule

// File: tb/tb_path_delay_probe_ctrl.sv
// Testbench for path_delay_probe_ctrl. Stimulus pushes the expected done
// cycle and tallies into a queue; a negedge monitor pops and compares on
// every done pulse. The chain model is either a 3-cycle non-inverting path
// or a same-cycle inverting path.
module tb_path_delay_probe_ctrl;

  localparam int SETTLE_W = 8;
  localparam int TRIAL_W  = 16;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start = 1'b0;
  logic [SETTLE_W-1:0] settle_cycles = '0;
  logic [TRIAL_W-1:0]  num_trials = '0;
  logic                expect_invert = 1'b0;
  logic                path_input;
  logic                path_result;
  logic                busy;
  logic                done;
  logic [TRIAL_W-1:0]  pass_count;
  logic [TRIAL_W-1:0]  fail_rise_count;
  logic [TRIAL_W-1:0]  fail_fall_count;

  path_delay_probe_ctrl #(.SETTLE_W(SETTLE_W), .TRIAL_W(TRIAL_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .settle_cycles(settle_cycles),
    .num_trials(num_trials), .expect_invert(expect_invert),
    .path_input(path_input), .path_result(path_result), .busy(busy),
    .done(done), .pass_count(pass_count), .fail_rise_count(fail_rise_count),
    .fail_fall_count(fail_fall_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Chain model: delayed version is valid at the third edge after launch.
  logic inv_mode = 1'b0;
  logic d0 = 1'b0, d1 = 1'b0;
  always @(posedge clk) begin
    d0 <= path_input;
    d1 <= d0;
  end
  assign path_result = inv_mode ? ~path_input : d1;

  typedef struct {
    int done_cyc;
    int p;
    int r;
    int f;
  } exp_t;
  exp_t sb[$];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int done_at(input int a, input int s, input int n);
    if (n == 0) return a + 1;
    return a + s + 2 + (n - 1) * (2 * s + 5) + s + 3;
  endfunction

  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_cycle", cyc, e.done_cyc);
        chk("busy_at_done", int'(busy), 0);
        chk("pass_count", int'(pass_count), e.p);
        chk("fail_rise_count", int'(fail_rise_count), e.r);
        chk("fail_fall_count", int'(fail_fall_count), e.f);
      end
    end
  end

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (busy && k < 5000) begin
      @(negedge clk);
      k++;
    end
    if (busy) chk(name, 1, 0);
    @(negedge clk);
  endtask

  task automatic run(input int s, input int n, input logic inv,
                     input int ep, input int er, input int ef);
    int a, t;
    logic lvl;
    @(negedge clk);
    settle_cycles = SETTLE_W'(s);
    num_trials    = TRIAL_W'(n);
    expect_invert = inv;
    start         = 1'b1;
    a   = cyc + 1;
    lvl = path_input;
    sb.push_back('{done_at(a, s, n), ep, er, ef});
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    if (n > 0) begin
      t = 0;
      while (path_input == lvl && t < 600) begin
        @(negedge clk);
        t++;
      end
      chk("first_launch_delay", cyc - a, s + 2);
    end
    wait_idle("run_timeout");
    if (n == 0) chk("path_input_unchanged", int'(path_input), int'(lvl));
  endtask

  initial begin
    int a, d1c, k;
    logic lvl;

    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_path_input", int'(path_input), 0);
    chk("rst_counts", int'(pass_count) + int'(fail_rise_count) + int'(fail_fall_count), 0);
    rst_n = 1'b1;

    // Settled captures: all pass.
    run(5, 4, 1'b0, 4, 0, 0);
    // Settle window shorter than the path: every capture stale.
    run(1, 6, 1'b0, 0, 3, 3);

    // Inverting same-cycle path.
    @(negedge clk);
    inv_mode = 1'b1;
    run(0, 2, 1'b1, 2, 0, 0);
    lvl = path_input;
    @(negedge clk);
    chk("level_kept_between_runs", int'(path_input), int'(lvl));
    run(0, 2, 1'b0, 0, 1, 1);
    @(negedge clk);
    inv_mode = 1'b0;

    // Empty run.
    run(3, 0, 1'b0, 0, 0, 0);

    // Reset during WAIT of trial 2 (E2 = A+37, WAIT spans A+38..A+42).
    @(negedge clk);
    settle_cycles = 8'd5;
    num_trials    = 16'd10;
    start         = 1'b1;
    a = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (cyc < a + 38 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("pass_before_reset", int'(pass_count), 2);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrun_rst_busy", int'(busy), 0);
    chk("midrun_rst_path_input", int'(path_input), 0);
    chk("midrun_rst_pass", int'(pass_count), 0);
    chk("midrun_rst_fails", int'(fail_rise_count) + int'(fail_fall_count), 0);
    rst_n = 1'b1;
    run(5, 2, 1'b0, 2, 0, 0);

    // start held high through a run while settle_cycles wanders.
    @(negedge clk);
    settle_cycles = 8'd2;
    num_trials    = 16'd3;
    expect_invert = 1'b0;
    start         = 1'b1;
    a   = cyc + 1;
    d1c = done_at(a, 2, 3);
    sb.push_back('{d1c, 3, 0, 0});
    @(negedge clk);
    while (cyc < d1c) begin
      settle_cycles = SETTLE_W'($urandom_range(0, 255));
      num_trials    = TRIAL_W'($urandom_range(1, 9));
      @(negedge clk);
    end
    settle_cycles = 8'd1;
    num_trials    = 16'd2;
    sb.push_back('{done_at(d1c + 1, 1, 2), 0, 1, 1});
    @(negedge clk);
    start = 1'b0;
    chk("rerun_accepted_after_done", int'(busy), 1);
    wait_idle("held_start_timeout");

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
